hdlc_rx_framer: RTL and testbench

Parametrised bit-serial HDLC receive framer for the HDLC controller: hunts flags, removes stuffed zeros, detects aborts, assembles bytes, optionally checks the CRC-16 FCS, and buffers one complete frame for the register interface to read. It generalises the receive path to a configurable maximum frame length and an optional FCS. It adds frame-length reporting, overflow detection and a drop command.

---
 rtl/hdlc_rx_framer.sv | 157 +++++++++++++++
 tb/tb_hdlc_rx_framer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_rx_framer.sv
// Bit-serial HDLC receive framer: flag hunt, zero deletion, abort,
// optional CRC-16 FCS check and a single-frame read buffer.
module hdlc_rx_framer #(
  parameter int MAX_FRAME = 128,
  parameter int FCS_EN    = 1,
  parameter int LEN_W     = $clog2(MAX_FRAME + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Rx,
  input  logic             RxEN,
  input  logic             Rx_Rd,
  input  logic             Rx_Drop,
  output logic [7:0]       DataOut,
  output logic             Rx_Ready,
  output logic [LEN_W-1:0] Rx_FrameSize,
  output logic             Rx_ValidFrame,
  output logic             Rx_FlagDetect,
  output logic             Rx_AbortSignal,
  output logic             Rx_FrameError,
  output logic             Rx_Overflow
);
  localparam int AW = $clog2(MAX_FRAME);
  localparam logic [LEN_W-1:0] MAXB = LEN_W'(MAX_FRAME);
  localparam logic [LEN_W-1:0] MINB = LEN_W'(1 + 2 * FCS_EN);
  localparam logic [LEN_W-1:0] FCSB = LEN_W'(2 * FCS_EN);
  localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);
  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] FLAG = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]       st_q, st_d;
  logic [7:0]       win_q, win_d, vld_q, vld_d, stf_q, stf_d;
  logic [2:0]       ones_q, ones_d, bitc_q, bitc_d;
  logic [6:0]       sr_q, sr_d;
  logic [LEN_W-1:0] byc_q, byc_d, rp_q, rp_d, size_q, size_d;
  logic [15:0]      crc_q, crc_d;
  logic             big_q, big_d, cap_q, cap_d, rdy_q, rdy_d, vf_q, vf_d;
  logic             fd_q, fd_d, ab_q, ab_d, fe_q, fe_d, ov_q, ov_d;
  logic             flag, abort, de, infr, ok, fb, we;
  logic [AW-1:0]    wa;
  logic [7:0]       wd;
  logic [7:0]       mem [MAX_FRAME];

  always_comb begin
    st_d = st_q; win_d = win_q; vld_d = vld_q; stf_d = stf_q;
    ones_d = ones_q; sr_d = sr_q; bitc_d = bitc_q; byc_d = byc_q;
    big_d = big_q; cap_d = cap_q; crc_d = crc_q;
    rp_d = rp_q; size_d = size_q; rdy_d = rdy_q; vf_d = vf_q;
    fd_d = 1'b0; ab_d = 1'b0; fe_d = 1'b0; ov_d = 1'b0;
    flag = 1'b0; abort = 1'b0; de = 1'b0; infr = 1'b0;
    ok = 1'b0; fb = 1'b0; we = 1'b0;
    wa = byc_q[AW-1:0];
    wd = {win_q[0], sr_q};

    if (Rx_Drop) begin
      rdy_d = 1'b0;
      rp_d  = '0;
    end else if (Rx_Rd && rdy_q) begin
      if (rp_q + ONE == size_q) begin
        rdy_d = 1'b0;
        rp_d  = '0;
      end else begin
        rp_d = rp_q + ONE;
      end
    end

    if (RxEN) begin
      // Raw bits sit 8 deep so flag bits can be voided before release
      win_d  = {Rx, win_q[7:1]};
      vld_d  = {1'b1, vld_q[7:1]};
      stf_d  = {~Rx && (ones_q == 3'd5), stf_q[7:1]};
      ones_d = Rx ? ((ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1) : 3'd0;
      flag   = ({Rx, win_q[7:1]} == 8'h7E);
      abort  = Rx && (ones_q == 3'd6);
      de     = vld_q[0] && !stf_q[0];
      infr   = (st_q == DATA) || ((st_q == FLAG) && de);

      if (de && (st_q != HUNT)) begin
        if (st_q == FLAG) begin
          st_d  = DATA;
          vf_d  = 1'b1;
          cap_d = !rdy_q;
        end
        fb     = crc_q[0] ^ win_q[0];
        crc_d  = {1'b0, crc_q[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
        sr_d   = {win_q[0], sr_q[6:1]};
        bitc_d = bitc_q + 3'd1;
        if (bitc_q == 3'd7) begin
          if (byc_q == MAXB) begin
            big_d = 1'b1;
          end else begin
            byc_d = byc_q + ONE;
            we    = cap_d;
          end
        end
      end

      if (flag) begin
        fd_d  = 1'b1;
        st_d  = FLAG;
        vld_d = '0;
        vf_d  = 1'b0;
        if (infr) begin
          ok = (bitc_d == 3'd0) && (byc_d >= MINB) && !big_d &&
               ((FCS_EN == 0) || (crc_d == 16'hF0B8));
          if (!ok) begin
            fe_d = 1'b1;
          end else if (cap_d) begin
            rdy_d  = 1'b1;
            size_d = byc_d - FCSB;
            rp_d   = '0;
          end else begin
            ov_d = 1'b1;
          end
        end
        crc_d  = 16'hFFFF;
        bitc_d = '0;
        byc_d  = '0;
        big_d  = 1'b0;
      end else if (abort) begin
        ab_d = infr;
        st_d = HUNT;
        vf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      st_q <= HUNT; win_q <= '0; vld_q <= '0; stf_q <= '0;
      ones_q <= '0; sr_q <= '0; bitc_q <= '0; byc_q <= '0;
      big_q <= 1'b0; cap_q <= 1'b0; crc_q <= 16'hFFFF;
      rp_q <= '0; size_q <= '0; rdy_q <= 1'b0; vf_q <= 1'b0;
      fd_q <= 1'b0; ab_q <= 1'b0; fe_q <= 1'b0; ov_q <= 1'b0;
    end else begin
      st_q <= st_d; win_q <= win_d; vld_q <= vld_d; stf_q <= stf_d;
      ones_q <= ones_d; sr_q <= sr_d; bitc_q <= bitc_d; byc_q <= byc_d;
      big_q <= big_d; cap_q <= cap_d; crc_q <= crc_d;
      rp_q <= rp_d; size_q <= size_d; rdy_q <= rdy_d; vf_q <= vf_d;
      fd_q <= fd_d; ab_q <= ab_d; fe_q <= fe_d; ov_q <= ov_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (we && !Rst) mem[wa] <= wd;
  end

  assign DataOut        = rdy_q ? mem[rp_q[AW-1:0]] : 8'h00;
  assign Rx_Ready       = rdy_q;
  assign Rx_FrameSize   = size_q;
  assign Rx_ValidFrame  = vf_q;
  assign Rx_FlagDetect  = fd_q;
  assign Rx_AbortSignal = ab_q;
  assign Rx_FrameError  = fe_q;
  assign Rx_Overflow    = ov_q;
endmodule

// File: tb/tb_hdlc_rx_framer.sv
// Directed bench for hdlc_rx_framer: one instance without FCS
// (MAX_FRAME=4) and one with FCS (MAX_FRAME=128).
module tb_hdlc_rx_framer;
  localparam bit DA = 1'b0;
  localparam bit DB = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rx_a, en_a, rd_a, dr_a, rx_b, en_b, rd_b, dr_b;
  logic [7:0] do_a, do_b;
  logic [2:0] sz_a;
  logic [7:0] sz_b;
  logic rdy_a, vf_a, fd_a, ab_a, fe_a, ov_a;
  logic rdy_b, vf_b, fd_b, ab_b, fe_b, ov_b;

  hdlc_rx_framer #(.MAX_FRAME(4), .FCS_EN(0)) u_a (
    .Clk(clk), .Rst(rst), .Rx(rx_a), .RxEN(en_a),
    .Rx_Rd(rd_a), .Rx_Drop(dr_a), .DataOut(do_a),
    .Rx_Ready(rdy_a), .Rx_FrameSize(sz_a),
    .Rx_ValidFrame(vf_a), .Rx_FlagDetect(fd_a),
    .Rx_AbortSignal(ab_a), .Rx_FrameError(fe_a),
    .Rx_Overflow(ov_a)
  );

  hdlc_rx_framer #(.MAX_FRAME(128), .FCS_EN(1)) u_b (
    .Clk(clk), .Rst(rst), .Rx(rx_b), .RxEN(en_b),
    .Rx_Rd(rd_b), .Rx_Drop(dr_b), .DataOut(do_b),
    .Rx_Ready(rdy_b), .Rx_FrameSize(sz_b),
    .Rx_ValidFrame(vf_b), .Rx_FlagDetect(fd_b),
    .Rx_AbortSignal(ab_b), .Rx_FrameError(fe_b),
    .Rx_Overflow(ov_b)
  );

  int nfd_a = 0, nab_a = 0, nfe_a = 0, nov_a = 0;
  int nfe_b = 0, nov_b = 0;
  always @(posedge clk) begin
    if (fd_a) nfd_a <= nfd_a + 1;
    if (ab_a) nab_a <= nab_a + 1;
    if (fe_a) nfe_a <= nfe_a + 1;
    if (ov_a) nov_a <= nov_a + 1;
    if (fe_b) nfe_b <= nfe_b + 1;
    if (ov_b) nov_b <= nov_b + 1;
  end

  int checks = 0;
  int failures = 0;
  int ones_tx = 0;
  logic [15:0] crc_tx = 16'hFFFF;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic bit_out(input bit s, input logic b);
    if (s) begin rx_b = b; en_b = 1'b1; end
    else begin rx_a = b; en_a = 1'b1; end
    @(posedge clk); #1;
    en_a = 1'b0;
    en_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic tx_raw(input bit s, input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) bit_out(s, v[i]);
  endtask

  task automatic tx_flag(input bit s);
    tx_raw(s, 32'h7E, 8);
    ones_tx = 0;
    crc_tx = 16'hFFFF;
  endtask

  task automatic tx_data(input bit s, input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      logic b;
      b = v[i];
      crc_tx = (crc_tx >> 1) ^ ((crc_tx[0] ^ b) ? 16'h8408 : 16'h0000);
      bit_out(s, b);
      if (b) begin
        ones_tx++;
        if (ones_tx == 5) begin
          bit_out(s, 1'b0);
          ones_tx = 0;
        end
      end else begin
        ones_tx = 0;
      end
    end
  endtask

  task automatic tx_frame(input bit s, input logic [63:0] by, input int nb,
                          input bit fcs, input logic [15:0] flip);
    logic [63:0] t;
    logic [15:0] f;
    tx_flag(s);
    for (int i = 0; i < nb; i++) begin
      t = by >> (8 * i);
      tx_data(s, t[31:0], 8);
    end
    if (fcs) begin
      f = ~crc_tx ^ flip;
      tx_data(s, {16'h0000, f}, 16);
    end
    tx_flag(s);
    idle(3);
  endtask

  task automatic pop(input bit s);
    if (s) rd_b = 1'b1; else rd_a = 1'b1;
    @(posedge clk); #1;
    rd_a = 1'b0;
    rd_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {rx_a, en_a, rd_a, dr_a, rx_b, en_b, rd_b, dr_b} = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_rdy_a", 32'(rdy_a), 0);
    chk("rst_do_a", 32'(do_a), 0);
    chk("rst_vf_a", 32'(vf_a), 0);
    chk("rst_fd_a", 32'(fd_a), 0);
    chk("rst_rdy_b", 32'(rdy_b), 0);
    chk("rst_sz_b", 32'(sz_b), 0);

    tx_flag(DA);
    tx_frame(DA, 64'hA50301, 3, 1'b0, 16'h0);
    chk("t1_flags", nfd_a, 3);
    chk("t1_rdy", 32'(rdy_a), 1);
    chk("t1_size", 32'(sz_a), 3);
    chk("t1_d0", 32'(do_a), 32'h01);
    pop(DA);
    chk("t1_d1", 32'(do_a), 32'h03);
    pop(DA);
    chk("t1_d2", 32'(do_a), 32'hA5);
    chk("t1_rdy_mid", 32'(rdy_a), 1);
    pop(DA);
    chk("t1_rdy_end", 32'(rdy_a), 0);
    chk("t1_fe", nfe_a, 0);

    tx_frame(DB, 64'hFFFFFFFF, 4, 1'b1, 16'h0);
    chk("t2_rdy", 32'(rdy_b), 1);
    chk("t2_size", 32'(sz_b), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_data", 32'(do_b), 32'hFF);
      pop(DB);
    end
    chk("t2_rdy_end", 32'(rdy_b), 0);
    chk("t2_fe", nfe_b, 0);
    tx_frame(DB, 64'hFFFFFFFF, 4, 1'b1, 16'h0100);
    chk("t2_bad_fe", nfe_b, 1);
    chk("t2_bad_rdy", 32'(rdy_b), 0);

    tx_flag(DA);
    tx_data(DA, 32'h55, 8);
    tx_raw(DA, 32'h7, 3);
    chk("t3_vf_in", 32'(vf_a), 1);
    tx_raw(DA, 32'h1F, 5);
    idle(2);
    chk("t3_abort", nab_a, 1);
    chk("t3_vf_out", 32'(vf_a), 0);
    chk("t3_fe", nfe_a, 0);
    tx_frame(DA, 64'h11, 1, 1'b0, 16'h0);
    chk("t3_rdy", 32'(rdy_a), 1);
    chk("t3_size", 32'(sz_a), 1);
    chk("t3_d0", 32'(do_a), 32'h11);
    pop(DA);
    chk("t3_rdy_end", 32'(rdy_a), 0);

    tx_frame(DA, 64'h5040302010, 5, 1'b0, 16'h0);
    chk("t4_long_fe", nfe_a, 1);
    chk("t4_long_rdy", 32'(rdy_a), 0);
    tx_flag(DA);
    tx_data(DA, 32'hABC, 12);
    tx_flag(DA);
    idle(3);
    chk("t4_bits_fe", nfe_a, 2);
    chk("t4_bits_rdy", 32'(rdy_a), 0);
    tx_frame(DA, 64'hEFBEADDE, 4, 1'b0, 16'h0);
    chk("t4_max_rdy", 32'(rdy_a), 1);
    chk("t4_max_size", 32'(sz_a), 4);
    chk("t4_max_d0", 32'(do_a), 32'hDE);

    tx_frame(DA, 64'h77, 1, 1'b0, 16'h0);
    chk("t5_ovf", nov_a, 1);
    chk("t5_rdy", 32'(rdy_a), 1);
    chk("t5_size", 32'(sz_a), 4);
    chk("t5_d0", 32'(do_a), 32'hDE);
    pop(DA);
    chk("t5_d1", 32'(do_a), 32'hAD);
    dr_a = 1'b1;
    rd_a = 1'b1;
    @(posedge clk); #1;
    dr_a = 1'b0;
    rd_a = 1'b0;
    chk("t5_drop_rdy", 32'(rdy_a), 0);
    chk("t5_fe", nfe_a, 2);

    tx_flag(DA);
    tx_data(DA, 32'h3C, 8);
    tx_data(DA, 32'h5, 4);
    chk("t6_vf_pre", 32'(vf_a), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_vf_rst", 32'(vf_a), 0);
    chk("t6_rdy_rst", 32'(rdy_a), 0);
    rst = 1'b0;
    tx_frame(DB, 64'h42, 1, 1'b1, 16'h0);
    chk("t6_rdy_b", 32'(rdy_b), 1);
    chk("t6_d_b", 32'(do_b), 32'h42);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rdy_b_rst", 32'(rdy_b), 0);
    chk("t6_sz_b_rst", 32'(sz_b), 0);
    chk("t6_do_b_rst", 32'(do_b), 0);
    rst = 1'b0;
    tx_frame(DA, 64'h99, 1, 1'b0, 16'h0);
    chk("t6_rdy_a", 32'(rdy_a), 1);
    chk("t6_size_a", 32'(sz_a), 1);
    chk("t6_d_a", 32'(do_a), 32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
